// File: rtl/regfile_arbiter.sv
// rtl/regfile_arbiter.sv - two-requester round-robin arbiter for a single-port synchronous-read register memory.
module regfile_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t              state_q, state_d;
    logic                win_b_q, win_b_d;
    logic                we_q, we_d;
    logic                last_b_q, last_b_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                a_ack_q, a_ack_d;
    logic                b_ack_q, b_ack_d;
    logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;

    logic                a_elig, b_elig, grant_b;

    always_comb begin
        state_d     = state_q;
        win_b_d     = win_b_q;
        we_d        = we_q;
        last_b_d    = last_b_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        a_ack_d     = 1'b0;
        b_ack_d     = 1'b0;
        a_rdata_d   = a_rdata_q;
        b_rdata_d   = b_rdata_q;

        // A requester whose ack is still showing is dropping that request, not asking again.
        a_elig  = a_req & ~a_ack_q;
        b_elig  = b_req & ~b_ack_q;
        grant_b = b_elig & (~a_elig | ~last_b_q);

        case (state_q)
            IDLE: begin
                if (a_elig | b_elig) begin
                    win_b_d     = grant_b;
                    last_b_d    = grant_b;
                    we_d        = grant_b ? b_we : a_we;
                    mem_en_d    = 1'b1;
                    mem_we_d    = grant_b ? b_we : a_we;
                    mem_addr_d  = grant_b ? b_addr : a_addr;
                    mem_wdata_d = grant_b ? b_wdata : a_wdata;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                state_d = DONE;
            end
            DONE: begin
                if (win_b_q) begin
                    b_ack_d = 1'b1;
                    if (!we_q) b_rdata_d = mem_rdata;
                end else begin
                    a_ack_d = 1'b1;
                    if (!we_q) a_rdata_d = mem_rdata;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            win_b_q     <= 1'b0;
            we_q        <= 1'b0;
            last_b_q    <= 1'b1;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            a_ack_q     <= 1'b0;
            b_ack_q     <= 1'b0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            win_b_q     <= win_b_d;
            we_q        <= we_d;
            last_b_q    <= last_b_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            a_ack_q     <= a_ack_d;
            b_ack_q     <= b_ack_d;
            a_rdata_q   <= a_rdata_d;
            b_rdata_q   <= b_rdata_d;
        end
    end

    assign a_ack     = a_ack_q;
    assign b_ack     = b_ack_q;
    assign a_rdata   = a_rdata_q;
    assign b_rdata   = b_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb/tb_regfile_arbiter.sv - directed self-checking bench for regfile_arbiter with a synchronous-read memory model.
module tb_regfile_arbiter;

    logic       clk;
    logic       reset;
    logic       a_req, a_we, b_req, b_we;
    logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
    logic       a_ack, b_ack;
    logic [7:0] a_rdata, b_rdata;
    logic       mem_en, mem_we;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    logic [7:0] mem [0:255];

    int total = 0;
    int bad   = 0;

    regfile_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_ack     (a_ack),
        .a_rdata   (a_rdata),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_ack     (b_ack),
        .b_rdata   (b_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_single(input bit pb, input bit we, input logic [7:0] addr,
                              input logic [7:0] wdata, input logic [7:0] exp_rd);
        @(negedge clk);
        if (pb) begin b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata; end
        else    begin a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata; end
        @(negedge clk);
        check("iss_en",    32'(mem_en), 1);
        check("iss_we",    32'(mem_we), 32'(we));
        check("iss_addr",  32'(mem_addr), 32'(addr));
        check("iss_wdata", 32'(mem_wdata), 32'(wdata));
        @(negedge clk);
        check("done_en",  32'(mem_en), 0);
        check("done_ack", 32'(a_ack | b_ack), 0);
        @(negedge clk);
        check("ack_own",   32'(pb ? b_ack : a_ack), 1);
        check("ack_other", 32'(pb ? a_ack : b_ack), 0);
        check("rdata",     32'(pb ? b_rdata : a_rdata), 32'(exp_rd));
        if (pb) b_req = 1'b0; else a_req = 1'b0;
        @(negedge clk);
        check("ack_pulse", 32'(pb ? b_ack : a_ack), 0);
        check("post_en",   32'(mem_en), 0);
    endtask

    initial begin
        int na, nb, nacks, last_cyc;
        reset = 1'b0;
        a_req = 1'b0; a_we = 1'b0; a_addr = 8'h00; a_wdata = 8'h00;
        b_req = 1'b0; b_we = 1'b0; b_addr = 8'h00; b_wdata = 8'h00;
        for (int i = 0; i < 4; i++) begin
            mem[8'h40 + i] = 8'(8'hA0 + i);
            mem[8'h80 + i] = 8'(8'hB0 + i);
        end
        mem[8'h3C] = 8'h3C;
        mem[8'hFF] = 8'h77;

        // reset with random inputs
        @(negedge clk);
        reset = 1'b1;
        a_req = 1'($urandom); a_we = 1'($urandom); a_addr = 8'($urandom); a_wdata = 8'($urandom);
        b_req = 1'($urandom); b_we = 1'($urandom); b_addr = 8'($urandom); b_wdata = 8'($urandom);
        @(negedge clk);
        check("rst_a_ack", 32'(a_ack), 0);
        check("rst_b_ack", 32'(b_ack), 0);
        check("rst_en",    32'(mem_en), 0);
        check("rst_we",    32'(mem_we), 0);
        check("rst_addr",  32'(mem_addr), 0);
        check("rst_wdata", 32'(mem_wdata), 0);
        check("rst_a_rd",  32'(a_rdata), 0);
        check("rst_b_rd",  32'(b_rdata), 0);
        a_req = 1'b0; b_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("idle_ack", 32'(a_ack | b_ack), 0);
            check("idle_en",  32'(mem_en), 0);
        end

        // single write then read on port A
        run_single(1'b0, 1'b1, 8'h10, 8'hA5, 8'h00);
        run_single(1'b0, 1'b0, 8'h10, 8'h00, 8'hA5);

        // contention from reset: both ports read 4 times each
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        a_req = 1'b1; a_we = 1'b0; a_addr = 8'h40; a_wdata = 8'h00;
        b_req = 1'b1; b_we = 1'b0; b_addr = 8'h80; b_wdata = 8'h00;
        na = 0; nb = 0; nacks = 0; last_cyc = 0;
        for (int cyc = 0; cyc < 60 && nacks < 8; cyc++) begin
            @(negedge clk);
            check("ctn_dual", 32'(a_ack & b_ack), 0);
            if (a_ack || b_ack) begin
                check("ctn_port", 32'(b_ack), 32'(nacks % 2));
                if (nacks > 0) check("ctn_gap", 32'(cyc - last_cyc), 3);
                last_cyc = cyc;
                if (a_ack) begin
                    check("ctn_a_rd", 32'(a_rdata), 32'(8'hA0 + na));
                    na++;
                    if (na == 4) a_req = 1'b0; else a_addr = 8'(8'h40 + na);
                end else begin
                    check("ctn_b_rd", 32'(b_rdata), 32'(8'hB0 + nb));
                    nb++;
                    if (nb == 4) b_req = 1'b0; else b_addr = 8'(8'h80 + nb);
                end
                nacks++;
            end
        end
        check("ctn_count", 32'(nacks), 8);
        a_req = 1'b0; b_req = 1'b0;
        repeat (3) @(negedge clk);

        // ack masking: B holds req through its ack cycle while A arrives
        b_req = 1'b1; b_we = 1'b0; b_addr = 8'h10;
        @(negedge clk);
        check("msk_b_iss", 32'(mem_addr), 32'h10);
        @(negedge clk);
        @(negedge clk);
        check("msk_b_ack", 32'(b_ack), 1);
        check("msk_b_rd",  32'(b_rdata), 32'hA5);
        a_req = 1'b1; a_we = 1'b1; a_addr = 8'h11; a_wdata = 8'h5A;
        @(negedge clk);
        check("msk_a_en",   32'(mem_en), 1);
        check("msk_a_addr", 32'(mem_addr), 32'h11);
        check("msk_a_we",   32'(mem_we), 1);
        check("msk_b_drop", 32'(b_ack), 0);
        b_req = 1'b0;
        @(negedge clk);
        check("msk_b_none", 32'(b_ack), 0);
        @(negedge clk);
        check("msk_a_ack", 32'(a_ack), 1);
        check("msk_b_zero", 32'(b_ack), 0);
        a_req = 1'b0;
        @(negedge clk);
        check("msk_quiet", 32'(mem_en), 0);

        // reset during ISSUE of an A read
        a_req = 1'b1; a_we = 1'b0; a_addr = 8'h10; a_wdata = 8'h00;
        @(negedge clk);
        check("mid_iss", 32'(mem_en), 1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_en",   32'(mem_en), 0);
        check("mid_ack",  32'(a_ack), 0);
        check("mid_a_rd", 32'(a_rdata), 0);
        reset = 1'b0;
        a_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_no_ack", 32'(a_ack), 0);
            check("mid_no_en",  32'(mem_en), 0);
        end
        run_single(1'b0, 1'b0, 8'h11, 8'h00, 8'h5A);

        // a write leaves the port's read data untouched
        run_single(1'b1, 1'b0, 8'h3C, 8'h00, 8'h3C);
        run_single(1'b1, 1'b1, 8'hFF, 8'h00, 8'h3C);
        check("mem_ff", 32'(mem[8'hFF]), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
